// File: rtl/pf_vf_mux_pkg.sv
// Shared PF/VF routing-table types, default field widths and table helpers
// used by the port-gasket TX arbiter/tagger.
package pf_vf_mux_pkg;

  localparam int PG_NUM_PORT = 4;
  localparam int PFVF_PF_W   = 3;
  localparam int PFVF_VF_W   = 11;
  localparam int MAX_PORT    = 64;
  localparam int PORT_IDX_W  = 6;

  typedef struct packed {
    logic [PFVF_PF_W-1:0]  pf;
    logic [PFVF_VF_W-1:0]  vf;
    logic                  vf_active;
    logic [PORT_IDX_W-1:0] pfvf_port;
  } t_pfvf_rtable_entry;

  // Sized for the largest legal port count; only the first NUM_PORT entries are searched.
  typedef t_pfvf_rtable_entry [MAX_PORT-1:0] t_pfvf_rtable;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  function automatic t_pfvf_rtable straight_rtable();
    t_pfvf_rtable t;
    for (int p = 0; p < MAX_PORT; p++) begin
      t[p].pf        = '0;
      t[p].vf        = PFVF_VF_W'(p);
      t[p].vf_active = 1'b1;
      t[p].pfvf_port = PORT_IDX_W'(p);
    end
    return t;
  endfunction

  // Lowest-indexed matching entry wins; an unowned port gets an all-zero entry.
  function automatic t_pfvf_rtable_entry port_to_entry(t_pfvf_rtable rtable, int num, int port);
    t_pfvf_rtable_entry e;
    e = '0;
    for (int i = num - 1; i >= 0; i--) begin
      if (int'(rtable[i].pfvf_port) == port) e = rtable[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/pg_vf_tx_skid.sv
// Two-entry AXI-S skid buffer; ready is a registered "not full" so the
// downstream ready never reaches the upstream ready combinationally.
module pg_vf_tx_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         push;
  logic         pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pg_vf_tx_arb_tagger.sv
// Packet-level round-robin merge of the per-VF TX streams with routing-table
// PF/VF stamping. Define PG_VF_TX_TAG_CHECK_EN to count AFU tag mismatches.
module pg_vf_tx_arb_tagger
  import pf_vf_mux_pkg::*;
#(
  parameter int           NUM_PORT = PG_NUM_PORT,
  parameter int           DATA_W   = 512,
  parameter int           PF_W     = PFVF_PF_W,
  parameter int           VF_W     = PFVF_VF_W,
  parameter t_pfvf_rtable RTABLE   = straight_rtable()
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORT-1:0]      in_tvalid,
  output logic [NUM_PORT-1:0]      in_tready,
  input  logic [NUM_PORT*DATA_W-1:0] in_tdata,
  input  logic [NUM_PORT-1:0]      in_tlast,
  input  logic [NUM_PORT*PF_W-1:0] in_pf,
  input  logic [NUM_PORT*VF_W-1:0] in_vf,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [DATA_W-1:0]        out_tdata,
  output logic                     out_tlast,
  output logic [PF_W-1:0]          out_pf,
  output logic [VF_W-1:0]          out_vf,
  output logic                     out_vf_active,
  output logic [15:0]              tag_err_cnt
);

  localparam int PTR_W  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int SKID_W = DATA_W + 1 + PF_W + VF_W + 1;

  t_arb_state       state_reg, state_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0] gnt_q_reg, gnt_q_next;
  logic [PTR_W-1:0] grant;
  logic             grant_valid;
  logic             skid_ready;
  logic             accept;

  logic [PF_W-1:0]  tag_pf  [NUM_PORT];
  logic [VF_W-1:0]  tag_vf  [NUM_PORT];
  logic             tag_act [NUM_PORT];

  logic [SKID_W-1:0] skid_in;
  logic [SKID_W-1:0] skid_out;

  // Each port's stamp is a constant resolved from the table at elaboration.
  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_tag
    localparam t_pfvf_rtable_entry ENT = port_to_entry(RTABLE, NUM_PORT, gi);
    assign tag_pf[gi]  = PF_W'(ENT.pf);
    assign tag_vf[gi]  = VF_W'(ENT.vf);
    assign tag_act[gi] = ENT.vf_active;
  end

  always_comb begin
    grant       = rr_ptr_reg;
    grant_valid = 1'b0;
    if (state_reg == ARB_LOCKED) begin
      grant       = gnt_q_reg;
      grant_valid = in_tvalid[gnt_q_reg];
    end else begin
      // Descending offset so the requester closest to rr_ptr is assigned last and wins.
      for (int k = NUM_PORT - 1; k >= 0; k--) begin
        if (in_tvalid[(int'(rr_ptr_reg) + k) % NUM_PORT]) begin
          grant       = PTR_W'((int'(rr_ptr_reg) + k) % NUM_PORT);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign accept = grant_valid && skid_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      rr_ptr_reg <= '0;
      gnt_q_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_q_reg  <= gnt_q_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_q_next  = gnt_q_reg;
    if (accept) begin
      if (in_tlast[grant]) begin
        state_next  = ARB_IDLE;
        rr_ptr_next = (int'(grant) == NUM_PORT - 1) ? '0 : grant + 1'b1;
      end else if (state_reg == ARB_IDLE) begin
        state_next = ARB_LOCKED;
        gnt_q_next = grant;
      end
    end
  end

  always_comb begin
    in_tready = '0;
    if (grant_valid && skid_ready) in_tready[grant] = 1'b1;
  end

  assign skid_in = {in_tdata[int'(grant)*DATA_W +: DATA_W], in_tlast[grant],
                    tag_pf[grant], tag_vf[grant], tag_act[grant]};

  pg_vf_tx_skid #(
    .W (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grant_valid),
    .in_ready  (skid_ready),
    .in_data   (skid_in),
    .out_valid (out_tvalid),
    .out_ready (out_tready),
    .out_data  (skid_out)
  );

  assign {out_tdata, out_tlast, out_pf, out_vf, out_vf_active} = skid_out;

`ifdef PG_VF_TX_TAG_CHECK_EN
  logic [15:0] tag_err_cnt_reg;
  logic        tag_mismatch;

  assign tag_mismatch = (in_pf[int'(grant)*PF_W +: PF_W] != tag_pf[grant]) ||
                        (in_vf[int'(grant)*VF_W +: VF_W] != tag_vf[grant]);

  // Every beat accepted while unlocked is the first beat of a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_err_cnt_reg <= '0;
    end else if (accept && (state_reg == ARB_IDLE) && tag_mismatch &&
                 (tag_err_cnt_reg != 16'hFFFF)) begin
      tag_err_cnt_reg <= tag_err_cnt_reg + 16'd1;
    end
  end

  assign tag_err_cnt = tag_err_cnt_reg;
`else
  logic unused_tag_inputs;
  assign unused_tag_inputs = ^{in_pf, in_vf};
  assign tag_err_cnt       = '0;
`endif

endmodule

// File: tb/tb_pg_vf_tx_arb_tagger.sv
// Directed bench for pg_vf_tx_arb_tagger: single packet, contention, lock,
// backpressure, mid-packet reset and the optional tag check.
module tb_pg_vf_tx_arb_tagger;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int PW = 3;
  localparam int VW = 11;

`ifdef PG_VF_TX_TAG_CHECK_EN
  localparam logic [15:0] EXP_ERR = 16'd1;
`else
  localparam logic [15:0] EXP_ERR = 16'd0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     in_tvalid = '0;
  logic [NP-1:0]     in_tready;
  logic [NP*DW-1:0]  in_tdata = '0;
  logic [NP-1:0]     in_tlast = '0;
  logic [NP*PW-1:0]  in_pf = '0;
  logic [NP*VW-1:0]  in_vf = '0;
  logic              out_tvalid;
  logic              out_tready = 1'b1;
  logic [DW-1:0]     out_tdata;
  logic              out_tlast;
  logic [PW-1:0]     out_pf;
  logic [VW-1:0]     out_vf;
  logic              out_vf_active;
  logic [15:0]       tag_err_cnt;

  pg_vf_tx_arb_tagger dut (
    .clk           (clk),
    .rst           (rst),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .in_tdata      (in_tdata),
    .in_tlast      (in_tlast),
    .in_pf         (in_pf),
    .in_vf         (in_vf),
    .out_tvalid    (out_tvalid),
    .out_tready    (out_tready),
    .out_tdata     (out_tdata),
    .out_tlast     (out_tlast),
    .out_pf        (out_pf),
    .out_vf        (out_vf),
    .out_vf_active (out_vf_active),
    .tag_err_cnt   (tag_err_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   data;
    logic          last;
    logic [PW-1:0] pf;
    logic [VW-1:0] vf;
    logic          act;
    int            cyc;
  } beat_t;

  beat_t got[$];
  beat_t expq[$];

  always @(negedge clk) begin
    if (!rst && out_tvalid && out_tready)
      got.push_back('{data: out_tdata[31:0], last: out_tlast, pf: out_pf,
                      vf: out_vf, act: out_vf_active, cyc: cyc});
  end

  int total = 0;
  int bad   = 0;

  int            n_pkt [NP];
  int            n_beat[NP];
  int            cur_pkt [NP];
  int            cur_beat[NP];
  logic [PW-1:0] s_pf[NP];
  logic [VW-1:0] s_vf[NP];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(int p, int k, int b);
    return 32'((p << 16) | (k << 8) | b);
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      in_tvalid[p]          = (cur_pkt[p] < n_pkt[p]);
      in_tlast[p]           = (cur_beat[p] == n_beat[p] - 1);
      in_tdata[p*DW +: DW]  = DW'(beat_word(p, cur_pkt[p], cur_beat[p]));
      in_pf[p*PW +: PW]     = s_pf[p];
      in_vf[p*VW +: VW]     = s_vf[p];
    end
  endtask

  // Samples the handshake before the edge, then advances each source that fired.
  task automatic tick();
    logic [NP-1:0] fire;
    fire = in_tvalid & in_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) begin
        cur_beat[p]++;
        if (cur_beat[p] == n_beat[p]) begin
          cur_beat[p] = 0;
          cur_pkt[p]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic start(input int p, input int pkts, input int beats);
    n_pkt[p]    = pkts;
    n_beat[p]   = beats;
    cur_pkt[p]  = 0;
    cur_beat[p] = 0;
    drive();
    #1;
  endtask

  function automatic bit srcs_done();
    for (int p = 0; p < NP; p++)
      if (cur_pkt[p] < n_pkt[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((!srcs_done() || out_tvalid) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_drain_bounded"}, 64'(n < max), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      n_pkt[p]    = 0;
      n_beat[p]   = 1;
      cur_pkt[p]  = 0;
      cur_beat[p] = 0;
    end
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    got.delete();
    expq.delete();
  endtask

  task automatic expect_pkt(input int p, input int k, input int beats);
    for (int b = 0; b < beats; b++)
      expq.push_back('{data: beat_word(p, k, b), last: (b == beats - 1), pf: '0,
                       vf: VW'(p), act: 1'b1, cyc: 0});
  endtask

  // Compares captured beats with the expected list; consecutive beats must be on consecutive cycles.
  task automatic check_out(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(expq[i].data));
      chk($sformatf("%s_last%0d", tag, i), 64'(got[i].last), 64'(expq[i].last));
      chk($sformatf("%s_pf%0d", tag, i),   64'(got[i].pf),   64'(expq[i].pf));
      chk($sformatf("%s_vf%0d", tag, i),   64'(got[i].vf),   64'(expq[i].vf));
      chk($sformatf("%s_act%0d", tag, i),  64'(got[i].act),  64'(expq[i].act));
      if (i > 0)
        chk($sformatf("%s_gap%0d", tag, i), 64'(got[i].cyc - got[i-1].cyc), 64'd1);
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      s_pf[p] = '0;
      s_vf[p] = VW'(p);
    end

    // Reset state
    do_reset();
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_tag_err_cnt", 64'(tag_err_cnt), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);

    // Single 3-beat packet from port 2
    start(2, 1, 3);
    chk("single_ready", 64'(in_tready), 64'b0100);
    chk("single_pre_valid", 64'(out_tvalid), 64'd0);
    tick();
    chk("single_lat_valid", 64'(out_tvalid), 64'd1);
    chk("single_lat_data", 64'(out_tdata[31:0]), 64'(beat_word(2, 0, 0)));
    chk("single_lat_vf", 64'(out_vf), 64'd2);
    drain("single", 20);
    expect_pkt(2, 0, 3);
    check_out("single");
    $display("single packet port 2 checked, total=%0d", total);

    // Contention: ports 0,1,3 with two 2-beat packets each
    do_reset();
    start(0, 2, 2);
    start(1, 2, 2);
    start(3, 2, 2);
    drain("contend", 40);
    expect_pkt(0, 0, 2);
    expect_pkt(1, 0, 2);
    expect_pkt(3, 0, 2);
    expect_pkt(0, 1, 2);
    expect_pkt(1, 1, 2);
    expect_pkt(3, 1, 2);
    check_out("contend");
    $display("contention ports 0/1/3 two rounds checked, total=%0d", total);

    // Lock: port 1 mid-packet, port 0 requests
    start(1, 1, 3);
    tick();
    start(0, 1, 2);
    chk("lock_ready_a", 64'(in_tready), 64'b0010);
    tick();
    chk("lock_ready_b", 64'(in_tready), 64'b0010);
    tick();
    chk("lock_ready_c", 64'(in_tready), 64'b0001);
    drain("lock", 20);
    expect_pkt(1, 0, 3);
    expect_pkt(0, 0, 2);
    check_out("lock");
    $display("lock port 1 over port 0 checked, total=%0d", total);

    // Backpressure: out_tready low for 5 cycles during a 4-beat packet
    out_tready = 1'b0;
    start(2, 1, 4);
    chk("bp_ready0", 64'(in_tready), 64'b0100);
    tick();
    chk("bp_ready1", 64'(in_tready), 64'b0100);
    tick();
    chk("bp_ready2", 64'(in_tready), 64'b0000);
    tick();
    chk("bp_ready3", 64'(in_tready), 64'b0000);
    tick();
    tick();
    chk("bp_ready5", 64'(in_tready), 64'b0000);
    chk("bp_held_valid", 64'(out_tvalid), 64'd1);
    chk("bp_held_data", 64'(out_tdata[31:0]), 64'(beat_word(2, 0, 0)));
    chk("bp_buffered_src", 64'(cur_beat[2]), 64'd2);
    out_tready = 1'b1;
    drain("bp", 20);
    expect_pkt(2, 0, 4);
    check_out("bp");
    $display("backpressure 4-beat packet checked, total=%0d", total);

    // Reset mid-packet, then a clean packet from port 3
    start(0, 1, 4);
    tick();
    tick();
    do_reset();
    chk("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);
    start(3, 1, 2);
    chk("midrst_ready", 64'(in_tready), 64'b1000);
    drain("midrst", 20);
    expect_pkt(3, 0, 2);
    check_out("midrst");
    $display("reset mid-packet then port 3 checked, total=%0d", total);

    // Tag check: port 1 supplies a wrong vf
    s_vf[1] = VW'(5);
    start(1, 1, 2);
    chk("tag_cnt_before", 64'(tag_err_cnt), 64'd0);
    tick();
    chk("tag_cnt_after", 64'(tag_err_cnt), 64'(EXP_ERR));
    chk("tag_out_vf", 64'(out_vf), 64'd1);
    drain("tag", 20);
    tick();
    chk("tag_cnt_final", 64'(tag_err_cnt), 64'(EXP_ERR));
    expect_pkt(1, 0, 2);
    check_out("tag");
    s_vf[1] = VW'(1);
    $display("tag check port 1 vf=5 checked, total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pg_vf_tx_arb_tagger.md
Name: pg_vf_tx_arb_tagger

Overview:
- Upstream (AFU-to-host) counterpart of the port-gasket PF/VF routing: the downstream mux steers host packets by PF/VF to a port; this block merges the PG_NUM_PORT PF0-VF port TX streams into one host-bound stream.
- Arbitrates round-robin at packet granularity.
- Stamps each granted packet's PF/VF/vf_active sideband with the routing-table entry that owns the granted port.
- Sits in the port gasket between the per-VF AFU ports and the static-region TX path.

Parameters:
- NUM_PORT, 4, number of VF ports; equals PG_NUM_PORT; legal range 1..64.
- DATA_W, 512, payload width per beat.
- PF_W, 3, pf field width.
- VF_W, 11, vf field width.
- RTABLE, straight map (entry p = pf 0, vf p, vf_active 1, pfvf_port p), array[NUM_PORT] of t_pfvf_rtable_entry.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_tvalid  in  NUM_PORT  per-port beat valid
- in_tready  out  NUM_PORT  per-port beat accept
- in_tdata  in  NUM_PORT*DATA_W  per-port payload
- in_tlast  in  NUM_PORT  per-port end of packet
- in_pf  in  NUM_PORT*PF_W  AFU-supplied pf (checked only)
- in_vf  in  NUM_PORT*VF_W  AFU-supplied vf (checked only)
- out_tvalid  out  1  merged beat valid
- out_tready  in  1  downstream accept
- out_tdata  out  DATA_W  merged payload
- out_tlast  out  1  merged end of packet
- out_pf  out  PF_W  stamped pf
- out_vf  out  VF_W  stamped vf
- out_vf_active  out  1  stamped vf_active
- tag_err_cnt  out  16  saturating mismatch count

Behaviour:
- Handshake: AXI-S semantics. A beat transfers when valid&&ready. Once valid is asserted, the source holds it and all fields stable until accepted.
- Reset values: out_tvalid=0, in_tready=0, tag_err_cnt=0, locked=0, rr_ptr=0. Other output data is don't-care while out_tvalid=0.
- FSM (per arbiter):
  - IDLE: no lock. Grant = first requester at or after rr_ptr, searching upward with wrap from NUM_PORT-1 to 0. Grant is combinational, so the first beat can transfer in the same cycle. If that beat has tlast=1, stay in IDLE and set rr_ptr=grant+1 mod NUM_PORT. Otherwise go to LOCKED with gnt_q=grant.
  - LOCKED: only port gnt_q may see in_tready. On acceptance of its tlast beat, go to IDLE and set rr_ptr=gnt_q+1 mod NUM_PORT.
  - Back-to-back packets from different ports have zero bubble cycles.
- Output stage: 2-entry skid buffer. Fixed latency of 1 cycle from input acceptance to out_tvalid.
- in_tready[g] = grant_valid && skid not full. The skid is registered, so out_tready does not combinationally reach in_tready.
- Full throughput of 1 beat/clk when out_tready=1.
- Tag: on every beat of port g, out_pf/out_vf/out_vf_active come from the RTABLE entry whose pfvf_port==g. The entry is resolved at elaboration into a per-port constant. The AFU-supplied in_pf/in_vf are never forwarded.
- Simultaneous requests: only one port is granted per cycle. Non-granted ports see in_tready=0 and hold their beat.
- out_tready low for N cycles: skid fills after 2 beats, in_tready drops, no beat is lost or duplicated.
- rst mid-packet: lock, rr_ptr, and skid are cleared on the next edge and buffered beats are discarded. Upstream reset-sync guarantees the sources also restart.
- NUM_PORT=1: arbiter degenerates; rr_ptr stays 0.

Optional Feature:
- Macro: PG_VF_TX_TAG_CHECK_EN.
- Defined: on every accepted first beat of a packet, compare in_pf/in_vf of port g with its table entry. On mismatch, tag_err_cnt increments by 1, saturating at 0xFFFF. The check is registered, so the count updates 1 cycle after the beat.
- Not defined: no comparator logic; tag_err_cnt is tied to 0; in_pf/in_vf are unused.

Decomposition:
- pf_vf_mux_pkg holds t_pfvf_rtable_entry, PF_W/VF_W defaults, and a function port_to_entry(rtable, port) returning the owning entry (default pf 0, vf 0, vf_active 0 if absent).
- Single sub-module: pg_vf_tx_skid (2-entry AXI-S skid buffer, width DATA_W+1+PF_W+VF_W+1).

Test Plan:
- Single packet: port 2 sends 3 beats (last on beat 3), out_tready=1 -> out shows 3 beats starting 1 cycle later, tlast on beat 3, out_pf=0, out_vf=2, out_vf_active=1.
- Contention: ports 0, 1, 3 each hold a 2-beat packet from cycle 0 -> output order 0,1,3, 6 consecutive beats, no bubbles; a second round starts at port 0 again.
- Lock: port 1 mid-packet while port 0 raises valid -> in_tready[0] stays 0 until port 1's tlast is accepted; port 0's packet follows with no interleaving.
- Backpressure: out_tready=0 for 5 cycles during a 4-beat packet -> exactly 2 beats buffered, in_tready=0 afterward; on release all 4 beats emerge in order, no loss or duplication.
- Reset mid-packet: rst pulsed at beat 2 of 4 -> next cycle out_tvalid=0 and rr_ptr=0; a new packet from port 3 is granted cleanly.
- With PG_VF_TX_TAG_CHECK_EN: port 1 sends in_vf=5 -> tag_err_cnt goes 0->1 one cycle after the first beat, and out_vf is still 1. Without the macro, tag_err_cnt stays 0.
